vscale_dmem_bridge: RTL
=======================

# vscale_dmem_bridge

Data-memory bridge between the core's two-phase dmem port and a word-wide valid/ready memory port. The core presents the address phase in DX and the store data one cycle later in WB. The bridge turns each access into one aligned word request with byte strobes, then extracts and sign- or zero-extends load data. It also stalls the core through `dmem_wait` and reports misaligned, errored or timed-out accesses on `dmem_badmem_e`.

## Interface

Parameters:
- `XPR_LEN`, 32: data and address width. Only 32 is supported.
- `TIMEOUT_CYCLES`, 256: maximum number of cycles in WAIT_RESP before the access is aborted as an error. Must be at least 2.

Ports:
- `clk` input 1: the single clock. All state is updated on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `dmem_en` input 1: address-phase valid from the core.
- `dmem_wen` input 1: address-phase write flag.
- `dmem_size` input 3: access type, funct3 encoding: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- `dmem_addr` input 32: byte address, address phase.
- `dmem_wdata_delayed` input 32: store data, valid in the data phase (one cycle after the address phase). Low-aligned.
- `dmem_wait` output 1: data phase not complete; the core holds both stages.
- `dmem_rdata` output 32: extended load data, valid when the data phase completes.
- `dmem_badmem_e` output 1: the data phase completes with an error.
- `mem_req_valid` output 1: memory request valid.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_req_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `mem_req_wen` output 1: write request.
- `mem_req_wmask` output 4: byte strobes. All zero for reads.
- `mem_req_wdata` output 32: lane-aligned store data.
- `mem_resp_valid` input 1: response valid, one pulse per accepted request.
- `mem_resp_rdata` input 32: raw read word.
- `mem_resp_err` input 1: the response is an error. Qualified by `mem_resp_valid`.

## Operation

- **Address-phase capture.** When `dmem_en` and `!dmem_wait`, latch `wen`, `size`, `addr[31:0]` into request registers. This cycle is the address phase, cycle N.
- **Misalignment check.** Performed at capture:
  - H/HU is misaligned when `addr[0]` = 1.
  - W is misaligned when `addr[1:0]` != 0.
  - Sizes 3, 6 and 7 are treated as misaligned.
- **States:** IDLE, ISSUE, WAIT_RESP, FAULT.
  - **IDLE:** on capture, go to ISSUE, or to FAULT if misaligned. Otherwise stay.
  - **ISSUE:**
    - Drive `mem_req_valid` = 1.
    - Drive `wdata` from `dmem_wdata_delayed` in the first ISSUE cycle; register it for any later ISSUE cycles.
    - Stay until `mem_req_ready`, then go to WAIT_RESP.
    - Request fields stay stable while valid is high without ready.
  - **WAIT_RESP:**
    - Count cycles.
    - On `mem_resp_valid`, complete the access. If `dmem_en` is high in that same cycle, go to ISSUE or FAULT for the new request; otherwise go to IDLE.
    - When the counter reaches `TIMEOUT_CYCLES`, complete the access with an error.
  - **FAULT:** a one-cycle data phase with no memory request. Completes with an error, then returns to IDLE or captures the next request.
- **Lane alignment for stores**, with o = `addr[1:0]`:
  - B: `wmask` = `4'b0001<<o`; data = `{4{wdata[7:0]}}`.
  - H: `wmask` = `4'b0011<<o`; data = `{2{wdata[15:0]}}`.
  - W: `wmask` = `4'b1111`; data = `wdata`.
- **Load extraction:**
  - B/BU select byte o; H/HU select halfword `o[1]`.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
  - Stores return `dmem_rdata` = 0.
- **`dmem_wait` = 1** in ISSUE, and in WAIT_RESP except in the completing cycle (response received or timeout). It is 0 in IDLE and FAULT.
- **`dmem_badmem_e` = 1** only in the completion cycle, when any of these holds: `mem_resp_err`, timeout, or FAULT.
- **Stray responses:** a `mem_resp_valid` received in IDLE, ISSUE or FAULT is ignored. A late response to a timed-out access is discarded.
- **Reset:** forces IDLE and clears the timeout counter.
  - Reset values: `mem_req_valid` = 0, `dmem_wait` = 0, `dmem_badmem_e` = 0, `dmem_rdata` = 0, `mem_req_wmask` = 0.
  - A reset asserted mid-access abandons the access. The response that follows is ignored.

## Timing

- **Minimum access:** address phase N; ISSUE in N+1 with `ready`=1; response in N+2.
  - `dmem_wait` is 1 in N+1 and 0 in N+2.
  - Load data and the error flag are driven combinationally from the response in N+2.
- **Back-to-back accesses:** a new address phase may coincide with the completion cycle of the previous access. No bubble is inserted.
- **Misaligned access:** the data phase completes in N+1 with `dmem_wait` = 0 and `dmem_badmem_e` = 1. No `mem_req_valid` is issued.
- **Timeout:** completes in the cycle where the WAIT_RESP count equals `TIMEOUT_CYCLES`, counting the first WAIT_RESP cycle as 1.
- **Outputs:** all memory-side outputs are registered or decoded from state only. No combinational path runs from `mem_req_ready` to `mem_req_valid`.

## Test plan

- **LBU:** LBU at 0x1003, response 0x80AA_BB00.
  - `mem_req_addr` = 0x1000 and `wmask` = 0.
  - Completion in N+2 with `dmem_rdata` = 0x0000_0080.
- **LB:** LB at the same address and data.
  - `dmem_rdata` = 0xFFFF_FF80.
- **SH with back-pressure:** SH at 0x2002, `wdata` = 0x1234_ABCD, `ready` held low for 3 cycles.
  - `wmask` = 4'b1100 and `mem_req_wdata` = 0xABCD_ABCD, both stable while stalled.
  - `dmem_wait` is high for 4 cycles.
- **Misaligned LW:** LW at 0x3001.
  - No `mem_req_valid`.
  - `dmem_badmem_e` = 1 and `dmem_wait` = 0 in N+1.
- **Timeout:** `TIMEOUT_CYCLES` = 4, with no response.
  - Completes with `badmem_e` after 4 WAIT_RESP cycles.
  - A response arriving 2 cycles later is ignored; the next load completes normally.
- **Reset mid-access, then back-to-back:**
  - Reset asserted while in WAIT_RESP: all outputs go to 0 the next cycle and the pending response is ignored.
  - After reset, two back-to-back LWs complete on consecutive response cycles with no idle cycle.

Source files
------------

// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge
//
// Bridges the core's two-phase data-memory port (address phase in DX, store
// data one cycle later in WB) onto a single word-wide valid/ready memory
// port. Each access becomes one aligned word request with byte strobes. Load
// data is lane-extracted and sign/zero extended. The core is stalled with
// dmem_wait. Misaligned, errored or timed-out accesses are flagged on
// dmem_badmem_e.
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   dmem_en/wen/size    - core address phase: valid, write flag, funct3 size
//   dmem_addr           - core byte address (address phase)
//   dmem_wdata_delayed  - core store data, low-aligned (data phase)
//   dmem_wait           - data phase not yet complete, core holds
//   dmem_rdata          - extended load data (valid in completion cycle)
//   dmem_badmem_e       - data phase completes with an error
//   mem_req_*           - word request: valid/ready, addr, wen, wmask, wdata
//   mem_resp_*          - response: valid pulse, raw word, error flag

module vscale_dmem_bridge #(
  parameter int XPR_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dmem_en,
  input  logic               dmem_wen,
  input  logic [2:0]         dmem_size,
  input  logic [XPR_LEN-1:0] dmem_addr,
  input  logic [XPR_LEN-1:0] dmem_wdata_delayed,
  output logic               dmem_wait,
  output logic [XPR_LEN-1:0] dmem_rdata,
  output logic               dmem_badmem_e,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XPR_LEN-1:0] mem_req_addr,
  output logic               mem_req_wen,
  output logic [3:0]         mem_req_wmask,
  output logic [XPR_LEN-1:0] mem_req_wdata,
  input  logic               mem_resp_valid,
  input  logic [XPR_LEN-1:0] mem_resp_rdata,
  input  logic               mem_resp_err
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_RESP = 2'd2;
  localparam logic [1:0] S_FAULT     = 2'd3;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // funct3 size encodings
  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  logic [1:0]         state;
  logic [1:0]         state_next;

  logic               req_wen;
  logic [2:0]         req_size;
  logic [XPR_LEN-1:0] req_addr;

  logic               issue_first;
  logic [XPR_LEN-1:0] wdata_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic               capture;
  logic               misaligned;
  logic               resp_done;
  logic               timeout_hit;
  logic               wait_complete;

  logic [XPR_LEN-1:0] lane_wdata;
  logic [3:0]         lane_mask;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [XPR_LEN-1:0] ld_ext;

  // Replicate low-aligned store data across all lanes of the word; the
  // byte strobes select which copy memory actually writes.
  function automatic logic [XPR_LEN-1:0] replicate(input logic [1:0]         sz,
                                                   input logic [XPR_LEN-1:0] d);
    logic [XPR_LEN-1:0] r;
    case (sz)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Address-phase checks on the live core inputs.
  always_comb begin
    misaligned = 1'b0;
    case (dmem_size)
      SZ_B, SZ_BU: misaligned = 1'b0;
      SZ_H, SZ_HU: misaligned = dmem_addr[0];
      SZ_W:        misaligned = (dmem_addr[1:0] != 2'b00);
      default:     misaligned = 1'b1;
    endcase
  end

  assign capture       = dmem_en && !dmem_wait;
  assign resp_done     = (state == S_WAIT_RESP) && mem_resp_valid;
  assign timeout_hit   = (state == S_WAIT_RESP) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign wait_complete = resp_done || timeout_hit;

  assign dmem_wait = (state == S_ISSUE) || ((state == S_WAIT_RESP) && !wait_complete);

  // Every state in which dmem_wait is low may accept the next address phase,
  // so back-to-back accesses need no idle bubble.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (capture) state_next = misaligned ? S_FAULT : S_ISSUE;
      end
      S_ISSUE: begin
        if (mem_req_ready) state_next = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (wait_complete) begin
          if (capture) state_next = misaligned ? S_FAULT : S_ISSUE;
          else         state_next = S_IDLE;
        end
      end
      S_FAULT: begin
        if (capture) state_next = misaligned ? S_FAULT : S_ISSUE;
        else         state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      req_wen     <= 1'b0;
      req_size    <= '0;
      req_addr    <= '0;
      issue_first <= 1'b0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
    end else begin
      state <= state_next;

      if (capture) begin
        req_wen  <= dmem_wen;
        req_size <= dmem_size;
        req_addr <= dmem_addr;
      end

      // High only in the first ISSUE cycle, when the core's store data is live.
      issue_first <= capture && !misaligned;

      if (issue_first) wdata_q <= lane_wdata;

      // The first WAIT_RESP cycle sees a count of 1.
      if ((state == S_WAIT_RESP) && !wait_complete)
        wait_cnt <= wait_cnt + CNT_W'(1);
      else if ((state == S_ISSUE) && mem_req_ready)
        wait_cnt <= CNT_W'(1);
      else
        wait_cnt <= '0;
    end
  end

  // Store lane alignment from the registered request.
  always_comb begin
    lane_wdata = replicate(req_size[1:0], dmem_wdata_delayed);
    case (req_size[1:0])
      2'd0:    lane_mask = 4'b0001 << req_addr[1:0];
      2'd1:    lane_mask = 4'b0011 << req_addr[1:0];
      default: lane_mask = 4'b1111;
    endcase
  end

  assign mem_req_valid = (state == S_ISSUE);
  assign mem_req_addr  = {req_addr[XPR_LEN-1:2], 2'b00};
  assign mem_req_wen   = req_wen;
  assign mem_req_wmask = req_wen ? lane_mask : 4'b0000;
  assign mem_req_wdata = issue_first ? lane_wdata : wdata_q;

  // Load extraction and extension.
  always_comb begin
    case (req_addr[1:0])
      2'd0:    ld_byte = mem_resp_rdata[7:0];
      2'd1:    ld_byte = mem_resp_rdata[15:8];
      2'd2:    ld_byte = mem_resp_rdata[23:16];
      default: ld_byte = mem_resp_rdata[31:24];
    endcase
    ld_half = req_addr[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];

    case (req_size)
      SZ_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      SZ_BU:   ld_ext = {24'd0, ld_byte};
      SZ_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      SZ_HU:   ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_resp_rdata;
    endcase
  end

  assign dmem_rdata    = (resp_done && !req_wen) ? ld_ext : '0;
  assign dmem_badmem_e = (state == S_FAULT) ||
                         (resp_done && mem_resp_err) ||
                         timeout_hit;

endmodule
